hilo_unit: RTL and testbench

Multiply/divide scheduler and HI/LO register owner for the pipelined MIPS core. Sits in the E stage beside the ALU and consumes the `HILOtype` code from the decoder. It starts multi-cycle mult/div operations, models their latency with a busy counter and commits results to HI/LO. It also serves mfhi/mflo/mthi/mtlo and raises the stall request that holds any HILO instruction in D while the unit is occupied.

---
 rtl/hilo_unit.sv | 149 ++++++++++++++
 tb/tb_hilo_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hilo_unit.sv
// HI/LO register owner and mult/div scheduler for the E stage.
// Results are computed at start and held pending until the busy counter expires.
module hilo_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_HILOtype,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_isHILO,
    output logic        start,
    output logic        busy,
    output logic [31:0] HILO_out,
    output logic        stall_HILO,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned DW    = 32;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    hi_q, hi_d, lo_q, lo_d;
    logic [DW-1:0]    pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic             pend_we_q, pend_we_d;

    logic             is_muldiv, is_mult;
    logic [2*DW-1:0]  prod_s, prod_u;
    logic [DW-1:0]    a_mag, b_mag, b_safe_u, b_safe_s;
    logic [DW-1:0]    q_u, r_u, q_m, r_m, q_s, r_s;
    logic             div_zero;
    logic [DW-1:0]    res_hi, res_lo;
    logic             res_we;

    assign is_muldiv = (E_HILOtype >= OP_MULT) && (E_HILOtype <= OP_DIVU);
    assign is_mult   = (E_HILOtype == OP_MULT) || (E_HILOtype == OP_MULTU);

    // Signed multiply via sign-extended operands; the low 64 bits are exact.
    assign prod_s = {{DW{E_A[DW-1]}}, E_A} * {{DW{E_B[DW-1]}}, E_B};
    assign prod_u = {{DW{1'b0}}, E_A} * {{DW{1'b0}}, E_B};

    // Signed divide in sign-magnitude; 0x80000000/-1 falls out as 0x80000000 rem 0.
    assign div_zero = (E_B == '0);
    assign a_mag    = E_A[DW-1] ? (~E_A + DW'(1)) : E_A;
    assign b_mag    = E_B[DW-1] ? (~E_B + DW'(1)) : E_B;
    assign b_safe_u = div_zero ? DW'(1) : E_B;
    assign b_safe_s = div_zero ? DW'(1) : b_mag;
    assign q_u      = E_A / b_safe_u;
    assign r_u      = E_A % b_safe_u;
    assign q_m      = a_mag / b_safe_s;
    assign r_m      = a_mag % b_safe_s;
    assign q_s      = (E_A[DW-1] ^ E_B[DW-1]) ? (~q_m + DW'(1)) : q_m;
    assign r_s      = E_A[DW-1] ? (~r_m + DW'(1)) : r_m;

    // Result selection for the op being started.
    always_comb begin
        res_hi = '0;
        res_lo = '0;
        res_we = 1'b1;
        case (E_HILOtype)
            OP_MULT:  begin res_hi = prod_s[2*DW-1:DW]; res_lo = prod_s[DW-1:0]; end
            OP_MULTU: begin res_hi = prod_u[2*DW-1:DW]; res_lo = prod_u[DW-1:0]; end
            OP_DIV:   begin res_hi = r_s; res_lo = q_s; res_we = ~div_zero; end
            OP_DIVU:  begin res_hi = r_u; res_lo = q_u; res_we = ~div_zero; end
            default:  res_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_we_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_we_q <= pend_we_d;
        end
    end

    // Next state: start in IDLE, count down in RUN, commit on the last busy cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_we_d = pend_we_q;
        start     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (is_muldiv) begin
                    start     = 1'b1;
                    pend_hi_d = res_hi;
                    pend_lo_d = res_lo;
                    pend_we_d = res_we;
                    cnt_d     = is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                    state_d   = S_RUN;
                end else if (E_HILOtype == OP_MTHI) begin
                    hi_d = E_A;
                end else if (E_HILOtype == OP_MTLO) begin
                    lo_d = E_A;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    if (pend_we_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy       = (state_q == S_RUN);
    assign stall_HILO = D_isHILO & (start | busy);
    assign HI         = hi_q;
    assign LO         = lo_q;
    assign HILO_out   = (E_HILOtype == OP_MFHI) ? hi_q :
                        (E_HILOtype == OP_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit: expected HI/LO queued at start, checked when busy falls.
module tb_hilo_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  E_HILOtype;
    logic [31:0] E_A, E_B;
    logic        D_isHILO;
    logic        start, busy, stall_HILO;
    logic [31:0] HILO_out, HI, LO;

    always #5 clk = ~clk;

    hilo_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .E_HILOtype(E_HILOtype), .E_A(E_A), .E_B(E_B),
        .D_isHILO(D_isHILO), .start(start), .busy(busy), .HILO_out(HILO_out),
        .stall_HILO(stall_HILO), .HI(HI), .LO(LO)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_hi = '0, m_lo = '0;
    int          errors = 0, checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive a mult/div start for one cycle and queue the expected outcome.
    task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        int          sa, sbv;
        longint      p;
        longint unsigned pu;
        e.hi = m_hi;
        e.lo = m_lo;
        e.cycles = (op <= 4'd2) ? 5 : 10;
        sa  = a;
        sbv = b;
        case (op)
            4'd1: begin p = longint'(sa) * longint'(sbv); e.hi = p[63:32]; e.lo = p[31:0]; end
            4'd2: begin pu = {32'b0, a} * {32'b0, b}; e.hi = pu[63:32]; e.lo = pu[31:0]; end
            4'd3: if (b != 0) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000; e.hi = 32'h0;
                end else begin
                    e.lo = 32'(sa / sbv); e.hi = 32'(sa % sbv);
                end
            end
            4'd4: if (b != 0) begin e.lo = a / b; e.hi = a % b; end
            default: ;
        endcase
        E_HILOtype = op; E_A = a; E_B = b;
        #1;
        check("start", {31'b0, start}, 32'd1);
        check("stall_start", {31'b0, stall_HILO}, {31'b0, D_isHILO});
        sb.push_back(e);
        tick;
        E_HILOtype = 4'd0;
    endtask

    // Count busy cycles (bounded), then pop and compare the committed HI/LO.
    task automatic wait_done(input string tag, output int stall_n);
        int   n = 0;
        exp_t e;
        stall_n = 0;
        while (busy === 1'b1 && n < 40) begin
            if (stall_HILO === 1'b1) stall_n++;
            n++;
            tick;
        end
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_busy_cycles"}, 32'(n), 32'(e.cycles));
            check({tag, "_HI"}, HI, e.hi);
            check({tag, "_LO"}, LO, e.lo);
            m_hi = e.hi;
            m_lo = e.lo;
        end
    endtask

    task automatic mt_op(input logic [3:0] op, input logic [31:0] a);
        E_HILOtype = op; E_A = a;
        tick;
        E_HILOtype = 4'd0;
        if (op == 4'd7) m_hi = a; else m_lo = a;
        check("mt_HI", HI, m_hi);
        check("mt_LO", LO, m_lo);
    endtask

    task automatic mf_check(input string tag, input logic [3:0] op, input logic [31:0] exp);
        E_HILOtype = op;
        #1;
        check(tag, HILO_out, exp);
        E_HILOtype = 4'd0;
        #1;
    endtask

    initial begin
        int sn;
        reset = 1'b0; E_HILOtype = '0; E_A = '0; E_B = '0; D_isHILO = 1'b0;
        tick; tick;
        reset = 1'b1;
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_HI", HI, 32'h0);
        check("rst_LO", LO, 32'h0);
        check("rst_start", {31'b0, start}, 32'd0);
        check("rst_out", HILO_out, 32'h0);

        // mult / multu / div / divu with the reference operands, back-to-back
        start_op(4'd1, 32'hFFFF_FFFD, 32'd5); wait_done("mult", sn);
        check("mult_HI_const", HI, 32'hFFFF_FFFF);
        start_op(4'd2, 32'hFFFF_FFFD, 32'd5); wait_done("multu", sn);
        check("multu_HI_const", HI, 32'h0000_0004);
        start_op(4'd3, 32'hFFFF_FFF9, 32'd2); wait_done("div", sn);
        check("div_LO_const", LO, 32'hFFFF_FFFD);
        start_op(4'd4, 32'd7, 32'd2); wait_done("divu", sn);

        // divide by zero leaves preloaded HI/LO intact
        mt_op(4'd7, 32'h11);
        mt_op(4'd8, 32'h22);
        start_op(4'd3, 32'd5, 32'd0); wait_done("div0", sn);
        mf_check("mfhi_div0", 4'd5, 32'h11);
        start_op(4'd4, 32'd9, 32'd0); wait_done("divu0", sn);
        mf_check("mflo_divu0", 4'd6, 32'h22);

        // stall window, ignored mthi and pre-commit mflo during busy
        D_isHILO = 1'b1;
        start_op(4'd1, 32'h0001_2345, 32'h0000_0100);
        E_HILOtype = 4'd7; E_A = 32'hBAD0_BAD0;
        #1;
        check("start_while_busy", {31'b0, start}, 32'd0);
        E_HILOtype = 4'd6;
        #1;
        check("mflo_precommit", HILO_out, m_lo);
        E_HILOtype = 4'd0;
        wait_done("stall_mult", sn);
        check("stall_busy_cycles", 32'(sn), 32'd5);
        check("stall_after", {31'b0, stall_HILO}, 32'd0);
        mf_check("mflo_product", 4'd6, 32'h0123_4500);
        D_isHILO = 1'b0;

        // mthi then mfhi; reserved op code
        mt_op(4'd7, 32'hDEAD_BEEF);
        mf_check("mfhi_deadbeef", 4'd5, 32'hDEAD_BEEF);
        E_HILOtype = 4'd12; E_A = 32'h5555_AAAA; E_B = 32'd3;
        #1;
        check("op12_out", HILO_out, 32'h0);
        check("op12_start", {31'b0, start}, 32'd0);
        tick;
        E_HILOtype = 4'd0;
        check("op12_HI", HI, m_hi);
        check("op12_busy", {31'b0, busy}, 32'd0);

        // reset in busy cycle 4 abandons the divide
        start_op(4'd4, 32'd100, 32'd7);
        tick; tick; tick;
        reset = 1'b0;
        tick;
        reset = 1'b1;
        sb.delete();
        m_hi = '0; m_lo = '0;
        check("rstmid_busy", {31'b0, busy}, 32'd0);
        check("rstmid_HI", HI, 32'h0);
        check("rstmid_LO", LO, 32'h0);
        repeat (12) tick;
        check("rstmid_late_busy", {31'b0, busy}, 32'd0);
        check("rstmid_late_LO", LO, 32'h0);

        // signed overflow, then a few random ops back-to-back
        start_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF); wait_done("div_ovf", sn);
        for (int i = 0; i < 6; i++) begin
            start_op(4'($urandom_range(1, 4)), $urandom, $urandom_range(0, 3) == 0 ? 32'($urandom_range(1, 9)) : $urandom);
            wait_done("rand", sn);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
